// File: rtl/unidad_pipe_ctrl_pkg.sv
// Shared definitions for the EX/MEM/WB control pipeline: ISA opcodes,
// per-stage control bundles and their bubble values.
package unidad_pipe_ctrl_pkg;

   localparam int REG_AW_DEF = 3;
   localparam int OPCODE_W   = 4;

   localparam logic [OPCODE_W-1:0] OP_NOP    = 4'b0000;
   localparam logic [OPCODE_W-1:0] OP_VADD   = 4'b0001;
   localparam logic [OPCODE_W-1:0] OP_VSUB   = 4'b0010;
   localparam logic [OPCODE_W-1:0] OP_VLOAD  = 4'b0011;
   localparam logic [OPCODE_W-1:0] OP_VSTORE = 4'b0100;
   localparam logic [OPCODE_W-1:0] OP_VMUL   = 4'b0101;
   localparam logic [OPCODE_W-1:0] OP_VAND   = 4'b0110;
   localparam logic [OPCODE_W-1:0] OP_VOR    = 4'b0111;
   localparam logic [OPCODE_W-1:0] OP_VXOR   = 4'b1000;
   localparam logic [OPCODE_W-1:0] OP_SADD   = 4'b1001;
   localparam logic [OPCODE_W-1:0] OP_SSUB   = 4'b1010;
   localparam logic [OPCODE_W-1:0] OP_SLOAD  = 4'b1011;
   localparam logic [OPCODE_W-1:0] OP_SMOVE  = 4'b1100;
   localparam logic [OPCODE_W-1:0] OP_BEQ    = 4'b1101;
   localparam logic [OPCODE_W-1:0] OP_JMP    = 4'b1110;
   localparam logic [OPCODE_W-1:0] OP_1111   = 4'b1111;

   typedef struct packed {
      logic sel_op;
      logic sel_ad;
      logic sel_int;
   } ex_ctrl_t;

   typedef struct packed {
      logic sum_mem;
      logic sel_mem;
      logic sel_data;
      logic mem_wr;
   } mem_ctrl_t;

   typedef struct packed {
      logic sel_wb;
      logic reg_wrv;
      logic reg_wrs;
   } wb_ctrl_t;

   localparam int EX_CTRL_W  = $bits(ex_ctrl_t);
   localparam int MEM_CTRL_W = $bits(mem_ctrl_t);
   localparam int WB_CTRL_W  = $bits(wb_ctrl_t);

   // A bubble carries no side effects anywhere down the pipe.
   localparam ex_ctrl_t            EX_BUBBLE     = '0;
   localparam mem_ctrl_t           MEM_BUBBLE    = '0;
   localparam wb_ctrl_t            WB_BUBBLE     = '0;
   localparam logic [OPCODE_W-1:0] BUBBLE_OPCODE = OP_NOP;

endpackage

// File: rtl/unidad_pipe_ctrl_hazard.sv
// Load-use hazard detection and front-end stall request.
module pipe_ctrl_hazard
   import unidad_pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              ex_valid,
   input  logic              ex_sel_mem,
   input  logic              ex_mem_wr,
   input  logic              ex_reg_wrv,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              id_reg_rdv,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              flush_in,
   input  logic              hold_in,
   output logic              hz,
   output logic              stall
);

   // Only a vector load in EX feeding a vector read in decode needs a bubble.
   assign hz = ex_valid & ex_sel_mem & ~ex_mem_wr & ex_reg_wrv & id_reg_rdv &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   assign stall = hz & ~flush_in & ~hold_in;

endmodule

// File: rtl/unidad_pipe_ctrl.sv
// EX/MEM/WB control pipeline registers with load-use bubbles, flush, hold
// and a saturating bubble counter.
module unidad_pipe_ctrl
   import unidad_pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] id_opcode,
   input  logic                id_sel_op,
   input  logic                id_sel_ad,
   input  logic                id_sel_int,
   input  logic                id_sum_mem,
   input  logic                id_sel_mem,
   input  logic                id_sel_data,
   input  logic                id_mem_wr,
   input  logic                id_sel_wb,
   input  logic                id_reg_wrv,
   input  logic                id_reg_wrs,
   input  logic                id_reg_rdv,
   input  logic                id_reg_rds,
   input  logic [REG_AW-1:0]   id_rd,
   input  logic [REG_AW-1:0]   id_rs1,
   input  logic [REG_AW-1:0]   id_rs2,
   input  logic                flush_in,
   input  logic                hold_in,
   output logic                stall_out,
   output logic                ex_valid,
   output logic                ex_sel_op,
   output logic                ex_sel_ad,
   output logic                ex_sel_int,
   output logic [OPCODE_W-1:0] ex_opcode,
   output logic [REG_AW-1:0]   ex_rd,
   output logic                mem_valid,
   output logic                mem_sum_mem,
   output logic                mem_sel_mem,
   output logic                mem_sel_data,
   output logic                mem_mem_wr,
   output logic [REG_AW-1:0]   mem_rd,
   output logic                wb_valid,
   output logic                wb_sel_wb,
   output logic                wb_reg_wrv,
   output logic                wb_reg_wrs,
   output logic [REG_AW-1:0]   wb_rd,
   output logic [CNT_W-1:0]    bubble_cnt
);

   typedef struct packed {
      logic                valid;
      logic [OPCODE_W-1:0] opcode;
      ex_ctrl_t            ex;
      mem_ctrl_t           mem;
      wb_ctrl_t            wb;
      logic [REG_AW-1:0]   rd;
   } ex_stage_t;

   typedef struct packed {
      logic              valid;
      mem_ctrl_t         mem;
      wb_ctrl_t          wb;
      logic [REG_AW-1:0] rd;
   } mem_stage_t;

   typedef struct packed {
      logic              valid;
      wb_ctrl_t          wb;
      logic [REG_AW-1:0] rd;
   } wb_stage_t;

   localparam ex_stage_t EX_STAGE_BUBBLE = '{valid: 1'b0, opcode: BUBBLE_OPCODE,
      ex: EX_BUBBLE, mem: MEM_BUBBLE, wb: WB_BUBBLE, rd: '0};
   localparam mem_stage_t MEM_STAGE_BUBBLE = '{valid: 1'b0, mem: MEM_BUBBLE,
      wb: WB_BUBBLE, rd: '0};
   localparam wb_stage_t WB_STAGE_BUBBLE = '{valid: 1'b0, wb: WB_BUBBLE, rd: '0};

   ex_stage_t        id_stage;
   ex_stage_t        ex_q;
   mem_stage_t       mem_q;
   wb_stage_t        wb_q;
   logic [CNT_W-1:0] bubble_q;
   logic             hz;
   logic             stall_raw;
   logic             unused_rds;

   // Scalar reads are decoded upstream but never create a hazard here.
   assign unused_rds = id_reg_rds;

   assign id_stage = '{
      valid:  1'b1,
      opcode: id_opcode,
      ex:     '{sel_op: id_sel_op, sel_ad: id_sel_ad, sel_int: id_sel_int},
      mem:    '{sum_mem: id_sum_mem, sel_mem: id_sel_mem, sel_data: id_sel_data,
                mem_wr: id_mem_wr},
      wb:     '{sel_wb: id_sel_wb, reg_wrv: id_reg_wrv, reg_wrs: id_reg_wrs},
      rd:     id_rd
   };

   pipe_ctrl_hazard #(.REG_AW(REG_AW)) u_hazard (
      .ex_valid   (ex_q.valid),
      .ex_sel_mem (ex_q.mem.sel_mem),
      .ex_mem_wr  (ex_q.mem.mem_wr),
      .ex_reg_wrv (ex_q.wb.reg_wrv),
      .ex_rd      (ex_q.rd),
      .id_reg_rdv (id_reg_rdv),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .flush_in   (flush_in),
      .hold_in    (hold_in),
      .hz         (hz),
      .stall      (stall_raw)
   );

   assign stall_out = stall_raw & ~reset;

   // NOTE: non-blocking assignments so each stage samples the pre-edge value of the stage ahead.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q     <= EX_STAGE_BUBBLE;
         mem_q    <= MEM_STAGE_BUBBLE;
         wb_q     <= WB_STAGE_BUBBLE;
         bubble_q <= '0;
      end else if (!hold_in) begin
         mem_q <= '{valid: ex_q.valid, mem: ex_q.mem, wb: ex_q.wb, rd: ex_q.rd};
         wb_q  <= '{valid: mem_q.valid, wb: mem_q.wb, rd: mem_q.rd};
         if (flush_in || hz) begin
            ex_q <= EX_STAGE_BUBBLE;
            if (bubble_q != {CNT_W{1'b1}}) bubble_q <= bubble_q + CNT_W'(1);
         end else begin
            ex_q <= id_stage;
         end
      end
   end

   assign ex_valid     = ex_q.valid;
   assign ex_sel_op    = ex_q.ex.sel_op;
   assign ex_sel_ad    = ex_q.ex.sel_ad;
   assign ex_sel_int   = ex_q.ex.sel_int;
   assign ex_opcode    = ex_q.opcode;
   assign ex_rd        = ex_q.rd;
   assign mem_valid    = mem_q.valid;
   assign mem_sum_mem  = mem_q.mem.sum_mem;
   assign mem_sel_mem  = mem_q.mem.sel_mem;
   assign mem_sel_data = mem_q.mem.sel_data;
   assign mem_mem_wr   = mem_q.mem.mem_wr;
   assign mem_rd       = mem_q.rd;
   assign wb_valid     = wb_q.valid;
   assign wb_sel_wb    = wb_q.wb.sel_wb;
   assign wb_reg_wrv   = wb_q.wb.reg_wrv;
   assign wb_reg_wrs   = wb_q.wb.reg_wrs;
   assign wb_rd        = wb_q.rd;
   assign bubble_cnt   = bubble_q;

endmodule

// File: tb/tb_unidad_pipe_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// three-slot instruction-queue model; a CNT_W=2 copy checks saturation.
module tb_unidad_pipe_ctrl;
   import unidad_pipe_ctrl_pkg::*;

   typedef struct packed {
      logic [3:0] opcode;
      logic       sel_op, sel_ad, sel_int;
      logic       sum_mem, sel_mem, sel_data, mem_wr;
      logic       sel_wb, reg_wrv, reg_wrs;
      logic       reg_rdv, reg_rds;
      logic [2:0] rd, rs1, rs2;
   } instr_t;

   typedef struct packed {
      logic   valid;
      instr_t i;
   } slot_t;

   logic   clk = 1'b0;
   logic   reset;
   logic   flush_in, hold_in;
   instr_t cur;

   logic       stall_out, ex_valid, ex_sel_op, ex_sel_ad, ex_sel_int;
   logic [3:0] ex_opcode;
   logic [2:0] ex_rd, mem_rd, wb_rd;
   logic       mem_valid, mem_sum_mem, mem_sel_mem, mem_sel_data, mem_mem_wr;
   logic       wb_valid, wb_sel_wb, wb_reg_wrv, wb_reg_wrs;
   logic [15:0] bubble_cnt;
   logic [25:0] s_vec;
   logic        s_stall;
   logic [1:0]  s_cnt;

   slot_t pipe [3];
   int    m_cnt;
   logic  last_stall;
   int    n_checks = 0;
   int    n_errors = 0;

   always #5 clk = ~clk;

   unidad_pipe_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_opcode(cur.opcode),
      .id_sel_op(cur.sel_op), .id_sel_ad(cur.sel_ad), .id_sel_int(cur.sel_int),
      .id_sum_mem(cur.sum_mem), .id_sel_mem(cur.sel_mem), .id_sel_data(cur.sel_data),
      .id_mem_wr(cur.mem_wr), .id_sel_wb(cur.sel_wb), .id_reg_wrv(cur.reg_wrv),
      .id_reg_wrs(cur.reg_wrs), .id_reg_rdv(cur.reg_rdv), .id_reg_rds(cur.reg_rds),
      .id_rd(cur.rd), .id_rs1(cur.rs1), .id_rs2(cur.rs2),
      .flush_in(flush_in), .hold_in(hold_in), .stall_out(stall_out),
      .ex_valid(ex_valid), .ex_sel_op(ex_sel_op), .ex_sel_ad(ex_sel_ad),
      .ex_sel_int(ex_sel_int), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_sum_mem(mem_sum_mem), .mem_sel_mem(mem_sel_mem),
      .mem_sel_data(mem_sel_data), .mem_mem_wr(mem_mem_wr), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_sel_wb(wb_sel_wb), .wb_reg_wrv(wb_reg_wrv),
      .wb_reg_wrs(wb_reg_wrs), .wb_rd(wb_rd), .bubble_cnt(bubble_cnt)
   );

   unidad_pipe_ctrl #(.REG_AW(3), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_opcode(cur.opcode),
      .id_sel_op(cur.sel_op), .id_sel_ad(cur.sel_ad), .id_sel_int(cur.sel_int),
      .id_sum_mem(cur.sum_mem), .id_sel_mem(cur.sel_mem), .id_sel_data(cur.sel_data),
      .id_mem_wr(cur.mem_wr), .id_sel_wb(cur.sel_wb), .id_reg_wrv(cur.reg_wrv),
      .id_reg_wrs(cur.reg_wrs), .id_reg_rdv(cur.reg_rdv), .id_reg_rds(cur.reg_rds),
      .id_rd(cur.rd), .id_rs1(cur.rs1), .id_rs2(cur.rs2),
      .flush_in(flush_in), .hold_in(hold_in), .stall_out(s_stall),
      .ex_valid(s_vec[25]), .ex_sel_op(s_vec[24]), .ex_sel_ad(s_vec[23]),
      .ex_sel_int(s_vec[22]), .ex_opcode(s_vec[21:18]), .ex_rd(s_vec[17:15]),
      .mem_valid(s_vec[14]), .mem_sum_mem(s_vec[13]), .mem_sel_mem(s_vec[12]),
      .mem_sel_data(s_vec[11]), .mem_mem_wr(s_vec[10]), .mem_rd(s_vec[9:7]),
      .wb_valid(s_vec[6]), .wb_sel_wb(s_vec[5]), .wb_reg_wrv(s_vec[4]),
      .wb_reg_wrs(s_vec[3]), .wb_rd(s_vec[2:0]), .bubble_cnt(s_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Decoder stand-in for the directed scenarios.
   function automatic instr_t mk(input logic [3:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs1, input logic [2:0] rs2);
      instr_t r = '0;
      r.opcode = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
      case (op)
         OP_VADD:   begin r.sel_op = 1; r.sel_wb = 1; r.reg_wrv = 1; r.reg_rdv = 1; end
         OP_VLOAD:  begin r.sum_mem = 1; r.sel_mem = 1; r.reg_wrv = 1; r.reg_rds = 1; end
         OP_VSTORE: begin r.sum_mem = 1; r.sel_mem = 1; r.sel_data = 1; r.mem_wr = 1;
                          r.reg_rdv = 1; end
         OP_VMUL:   begin r.sel_op = 1; r.sel_ad = 1; r.reg_rds = 1; end
         OP_SMOVE:  begin r.sel_int = 1; r.reg_wrs = 1; r.reg_rds = 1; end
         default:   ;
      endcase
      return r;
   endfunction

   function automatic instr_t rand_instr();
      logic [31:0] rv;
      instr_t      r;
      rv = $urandom;
      r = rv[24:0];
      r.rd  = 3'($urandom_range(0, 3));
      r.rs1 = 3'($urandom_range(0, 3));
      r.rs2 = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
         r.sel_mem = 1'b1; r.mem_wr = 1'b0; r.reg_wrv = 1'b1;
      end
      return r;
   endfunction

   function automatic logic model_hz();
      instr_t e = pipe[0].i;
      return pipe[0].valid && e.sel_mem && !e.mem_wr && e.reg_wrv && cur.reg_rdv &&
             (e.rd == cur.rs1 || e.rd == cur.rs2);
   endfunction

   function automatic logic [25:0] exp_vec();
      instr_t e = pipe[0].i;
      instr_t m = pipe[1].i;
      instr_t w = pipe[2].i;
      return {pipe[0].valid, e.sel_op, e.sel_ad, e.sel_int, e.opcode, e.rd,
              pipe[1].valid, m.sum_mem, m.sel_mem, m.sel_data, m.mem_wr, m.rd,
              pipe[2].valid, w.sel_wb, w.reg_wrv, w.reg_wrs, w.rd};
   endfunction

   task automatic check_outputs();
      logic [25:0] ev = exp_vec();
      check("ex",  {ex_valid, ex_sel_op, ex_sel_ad, ex_sel_int, ex_opcode, ex_rd}, ev[25:15]);
      check("mem", {mem_valid, mem_sum_mem, mem_sel_mem, mem_sel_data, mem_mem_wr, mem_rd},
            ev[14:7]);
      check("wb",  {wb_valid, wb_sel_wb, wb_reg_wrv, wb_reg_wrs, wb_rd}, ev[6:0]);
      check("bubble_cnt", bubble_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
      check("sat_ctrl", s_vec, ev);
      check("sat_cnt", s_cnt, (m_cnt > 3) ? 3 : m_cnt);
   endtask

   // One clock: present decode, check the stall request, clock, check stages.
   task automatic step(input instr_t ins, input logic fl, input logic hd);
      logic hz;
      cur = ins; flush_in = fl; hold_in = hd;
      #1;
      hz = model_hz();
      last_stall = hz && !fl && !hd;
      check("stall_out", stall_out, last_stall);
      check("sat_stall", s_stall, last_stall);
      @(posedge clk);
      if (!hd) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (fl || hz) begin
            pipe[0] = '0;
            m_cnt++;
         end else begin
            pipe[0] = '{valid: 1'b1, i: ins};
         end
      end
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      m_cnt = 0;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      clear_model();
      check_outputs();
      check("rst_stall", stall_out, 1'b0);
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      instr_t nxt;
      int     base;
      reset = 1'b1; flush_in = 1'b0; hold_in = 1'b0; cur = '0;
      clear_model();
      #2;
      check_outputs();
      @(negedge clk);
      reset = 1'b0;

      // Reset mid-stream, then a fresh VADD reaches WB three edges later.
      step(mk(OP_VADD, 1, 2, 3), 0, 0);
      step(mk(OP_VADD, 2, 4, 5), 0, 0);
      do_reset();
      check("rst_cnt", bubble_cnt, 0);
      step(mk(OP_VADD, 1, 6, 7), 0, 0);
      step(mk(OP_NOP, 0, 0, 0), 0, 0);
      step(mk(OP_NOP, 0, 0, 0), 0, 0);
      check("rst_wb_wrv", wb_reg_wrv, 1'b1);

      // Latency across three consecutive opcodes.
      step(mk(OP_VADD, 1, 6, 7), 0, 0);
      check("lat_ex0", ex_opcode, OP_VADD);
      step(mk(OP_VMUL, 2, 0, 0), 0, 0);
      check("lat_ex1", ex_opcode, OP_VMUL);
      step(mk(OP_SMOVE, 3, 0, 0), 0, 0);
      check("lat_ex2", ex_opcode, OP_SMOVE);
      check("lat_wb0", {wb_reg_wrv, wb_reg_wrs}, 2'b10);
      step(mk(OP_NOP, 0, 0, 0), 0, 0);
      check("lat_wb1", {wb_reg_wrv, wb_reg_wrs}, 2'b00);
      step(mk(OP_NOP, 0, 0, 0), 0, 0);
      check("lat_wb2", {wb_reg_wrv, wb_reg_wrs}, 2'b01);

      // Load-use: one bubble, then the consumer enters EX.
      base = m_cnt;
      step(mk(OP_VLOAD, 3, 0, 0), 0, 0);
      step(mk(OP_VADD, 1, 3, 0), 0, 0);
      check("lu_stall", last_stall, 1'b1);
      check("lu_bubble", ex_valid, 1'b0);
      check("lu_cnt", bubble_cnt, base + 1);
      step(mk(OP_VADD, 1, 3, 0), 0, 0);
      check("lu_enter", {ex_valid, ex_opcode}, {1'b1, OP_VADD});
      step(mk(OP_VLOAD, 3, 0, 0), 0, 0);
      step(mk(OP_VADD, 1, 4, 5), 0, 0);
      check("lu_nomatch", bubble_cnt, base + 1);

      // A store in EX never stalls a reader of its rd.
      step(mk(OP_VSTORE, 3, 0, 1), 0, 0);
      step(mk(OP_VADD, 1, 3, 0), 0, 0);
      check("st_nostall", {ex_valid, ex_opcode}, {1'b1, OP_VADD});
      check("st_cnt", bubble_cnt, base + 1);

      // Flush coinciding with a hazard; a flushed store never writes.
      step(mk(OP_VLOAD, 2, 0, 0), 0, 0);
      step(mk(OP_VADD, 1, 2, 0), 1, 0);
      check("fl_bubble", ex_valid, 1'b0);
      check("fl_cnt", bubble_cnt, base + 2);
      step(mk(OP_VSTORE, 0, 0, 0), 1, 0);
      step(mk(OP_NOP, 0, 0, 0), 0, 0);
      check("fl_store", mem_mem_wr, 1'b0);

      // Hold for five cycles with a store parked in MEM.
      step(mk(OP_VSTORE, 4, 5, 6), 0, 0);
      step(mk(OP_NOP, 0, 0, 0), 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(mk(OP_VLOAD, 1, 1, 1), 0, 1);
         check("hold_memwr", mem_mem_wr, 1'b1);
         check("hold_cnt", bubble_cnt, base + 3);
      end
      step(mk(OP_NOP, 0, 0, 0), 0, 0);

      // Saturation of the narrow counter.
      do_reset();
      for (int k = 0; k < 5; k++) step(mk(OP_VADD, 1, 0, 0), 1, 0);
      check("sat_2b", s_cnt, 2'd3);
      check("sat_16b", bubble_cnt, 16'd5);

      // Random traffic with the front end honouring stall and hold.
      nxt = rand_instr();
      for (int c = 0; c < 3000; c++) begin
         logic fl, hd;
         if ($urandom_range(0, 199) == 0) do_reset();
         fl = ($urandom_range(0, 9) == 0);
         hd = ($urandom_range(0, 9) == 0);
         step(nxt, fl, hd);
         if (!last_stall && !hd) nxt = rand_instr();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
